memoria_de_instrucoes_carregavel: RTL

Parametrised, run-time loadable instruction memory replacing the fixed-content instruction ROM. A bootloader (e.g. UART receiver) streams program words in through a valid/ready handshake. The CPU then fetches instructions with one-cycle registered latency. Fetches beyond the loaded program length return a HALT word and raise an error flag, so the core stops cleanly instead of executing garbage.

---
 rtl/memoria_de_instrucoes_carregavel_if.sv | 30 +++
 rtl/memoria_de_instrucoes_carregavel.sv | 110 +++++++++++
 2 files changed

// File: rtl/memoria_de_instrucoes_carregavel_if.sv
// Bus between the bootloader/CPU side and the loadable instruction memory.
// Carries the load stream (valid/ready), load control, fetch request and fetch result.
// Master drives requests and load words; slave returns ready, completion and instructions.
interface memoria_de_instrucoes_carregavel_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 26
);
  logic                  carregar;
  logic [ADDR_WIDTH-1:0] tamanho;
  logic [DATA_WIDTH-1:0] dado_carga;
  logic                  dado_valido;
  logic                  dado_pronto;
  logic                  carga_concluida;
  logic                  ler;
  logic [ADDR_WIDTH-1:0] pc;
  logic [DATA_WIDTH-1:0] instrucao;
  logic                  instrucao_valida;
  logic                  pc_invalido;
  logic [1:0]            estado;

  modport master (
    output carregar, tamanho, dado_carga, dado_valido, ler, pc,
    input  dado_pronto, carga_concluida, instrucao, instrucao_valida, pc_invalido, estado
  );

  modport slave (
    input  carregar, tamanho, dado_carga, dado_valido, ler, pc,
    output dado_pronto, carga_concluida, instrucao, instrucao_valida, pc_invalido, estado
  );
endinterface

// File: rtl/memoria_de_instrucoes_carregavel.sv
// Run-time loadable instruction memory: bootloader streams words in, CPU fetches them out.
// Fetch latency: one cycle (registered instrucao); load accepts one word per cycle.
// Backpressure: dado_pronto is high only while loading; out-of-range fetches return HALT_WORD.
module memoria_de_instrucoes_carregavel #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 26,
  parameter int                    MEM_SIZE   = 150,
  parameter logic [DATA_WIDTH-1:0] HALT_WORD  = 32'h60000000
) (
  input  logic clock,
  input  logic reset,
  memoria_de_instrucoes_carregavel_if.slave bus
);

  // PW holds counts 0..MEM_SIZE; IW indexes words 0..MEM_SIZE-1.
  localparam int PW = $clog2(MEM_SIZE + 1);
  localparam int IW = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1;

  typedef enum logic [1:0] {
    OCIOSO   = 2'd0,
    CARGA    = 2'd1,
    EXECUCAO = 2'd2
  } estado_t;

  logic [DATA_WIDTH-1:0] mem [0:MEM_SIZE-1];

  estado_t       estado_q, estado_d;
  logic [PW-1:0] ptr, len_q, limite, len_eff;
  logic          inicia, escreve, ultima, leitura, pc_ok;

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) estado_q <= OCIOSO;
    else        estado_q <= estado_d;
  end

  // Next-state and handshake decode; a new load is only accepted outside CARGA.
  always_comb begin
    estado_d = estado_q;
    len_eff  = bus.tamanho[PW-1:0];
    inicia   = 1'b0;
    escreve  = 1'b0;
    ultima   = 1'b0;
    leitura  = 1'b0;
    pc_ok    = 1'b0;

    if (bus.tamanho >= ADDR_WIDTH'(MEM_SIZE)) len_eff = PW'(MEM_SIZE);

    inicia  = bus.carregar && (estado_q != CARGA);
    escreve = (estado_q == CARGA) && bus.dado_valido && bus.dado_pronto;
    ultima  = escreve && (ptr == len_q - PW'(1));
    // A fetch in the same cycle as a restart is dropped.
    leitura = (estado_q == EXECUCAO) && bus.ler && !bus.carregar;
    // Full-width unsigned compare so high pc bits are never aliased into range.
    pc_ok   = bus.pc < ADDR_WIDTH'(limite);

    case (estado_q)
      OCIOSO, EXECUCAO: begin
        if (inicia) estado_d = (len_eff == '0) ? EXECUCAO : CARGA;
      end
      CARGA: begin
        if (ultima) estado_d = EXECUCAO;
      end
      default: estado_d = OCIOSO;
    endcase
  end

  // Load bookkeeping: pointer, latched length, fetch limit, ready and completion pulse.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ptr                 <= '0;
      len_q               <= '0;
      limite              <= '0;
      bus.dado_pronto     <= 1'b0;
      bus.carga_concluida <= 1'b0;
    end else begin
      bus.dado_pronto     <= (estado_d == CARGA);
      bus.carga_concluida <= ultima || (inicia && (len_eff == '0));
      if (inicia) begin
        ptr    <= '0;
        len_q  <= len_eff;
        limite <= '0;
      end else if (escreve) begin
        ptr <= ptr + PW'(1);
        if (ultima) limite <= len_q;
      end
    end
  end

  // Storage array; contents deliberately survive reset.
  always_ff @(posedge clock) begin
    if (escreve) mem[ptr[IW-1:0]] <= bus.dado_carga;
  end

  // Registered fetch port; instrucao holds between fetches.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      bus.instrucao        <= '0;
      bus.instrucao_valida <= 1'b0;
      bus.pc_invalido      <= 1'b0;
    end else begin
      bus.instrucao_valida <= leitura;
      bus.pc_invalido      <= leitura && !pc_ok;
      if (leitura) bus.instrucao <= pc_ok ? mem[bus.pc[IW-1:0]] : HALT_WORD;
    end
  end

  assign bus.estado = estado_q;

endmodule
